// File: rtl/word_sequencer.sv
// Word-level sequencer for a bank of letter readers: restarts the readers,
// matches their letter-hit pulses against a latched target word.
module word_sequencer #(
    parameter int unsigned NUM_LETTERS = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned MAX_LEN     = 4,
    parameter int unsigned LEN_W       = 3,
    parameter int unsigned GAP_LIMIT   = 8,
    parameter int unsigned GAP_W       = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [NUM_LETTERS-1:0]     letter_hit,
    input  logic [MAX_LEN*IDX_W-1:0]   word_cfg,
    input  logic [LEN_W-1:0]           word_len,
    output logic                       reader_restart,
    output logic                       word_found,
    output logic                       word_error,
    output logic [LEN_W-1:0]           progress,
    output logic                       busy
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [MAX_LEN*IDX_W-1:0]   cfg_q, cfg_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [GAP_W-1:0]           gap_q, gap_d, gap_inc;
    logic [LEN_W-1:0]           prog_d, prog_inc;
    logic [IDX_W-1:0]           cur_idx;
    logic [NUM_LETTERS-1:0]     want_hit;
    logic                       len_ok, hit_match;
    logic                       restart_d, found_d, error_d, busy_d;

    // Expected one-hot hit for the next letter; out-of-range indices give no bit.
    always_comb begin
        cur_idx  = '0;
        want_hit = '0;
        for (int k = 0; k < int'(MAX_LEN); k++) begin
            if (progress == LEN_W'(k)) begin
                cur_idx = cfg_q[k*IDX_W +: IDX_W];
            end
        end
        for (int i = 0; i < int'(NUM_LETTERS); i++) begin
            if (cur_idx == IDX_W'(i)) begin
                want_hit[i] = 1'b1;
            end
        end
    end

    assign hit_match = (want_hit != '0) && (letter_hit == want_hit);
    assign len_ok    = (word_len != '0) && (word_len <= LEN_W'(MAX_LEN));
    assign gap_inc   = gap_q + GAP_W'(1);
    assign prog_inc  = progress + LEN_W'(1);

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        len_d   = len_q;
        gap_d   = gap_q;
        prog_d  = progress;

        case (state_q)
            ST_IDLE: begin
                prog_d = '0;
                gap_d  = '0;
                if (enable && len_ok) begin
                    state_d = ST_ARM;
                    cfg_d   = word_cfg;
                    len_d   = word_len;
                end
            end
            ST_ARM: begin
                prog_d  = '0;
                gap_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (letter_hit == '0) begin
                    if (progress != '0) begin
                        gap_d = gap_inc;
                        if (gap_inc == GAP_W'(GAP_LIMIT)) begin
                            state_d = ST_FAIL;
                            prog_d  = '0;
                            gap_d   = '0;
                        end
                    end
                end else if (hit_match) begin
                    prog_d = prog_inc;
                    gap_d  = '0;
                    if (prog_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_FAIL;
                    prog_d  = '0;
                    gap_d   = '0;
                end
            end
            ST_DONE, ST_FAIL: begin
                prog_d  = '0;
                gap_d   = '0;
                state_d = ST_ARM;
            end
            default: begin
                prog_d  = '0;
                gap_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Disable wins over everything, including a completing word.
        if (!enable) begin
            state_d = ST_IDLE;
            prog_d  = '0;
            gap_d   = '0;
        end

        restart_d = (state_d != ST_RUN);
        found_d   = (state_d == ST_DONE);
        error_d   = (state_d == ST_FAIL);
        busy_d    = (state_d == ST_RUN) && (prog_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cfg_q          <= '0;
            len_q          <= '0;
            gap_q          <= '0;
            progress       <= '0;
            reader_restart <= 1'b1;
            word_found     <= 1'b0;
            word_error     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            cfg_q          <= cfg_d;
            len_q          <= len_d;
            gap_q          <= gap_d;
            progress       <= prog_d;
            reader_restart <= restart_d;
            word_found     <= found_d;
            word_error     <= error_d;
            busy           <= busy_d;
        end
    end

endmodule
